// File: rtl/vec_slice_pkg.sv
// vec_slice_pkg: FSM state encoding and reduction mode constants for vec_slice_reduce
package vec_slice_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic [1:0] MODE_OR   = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;
endpackage

// File: rtl/vec_slice_reduce_slice.sv
// slice_reduce: combinational OR/AND/XOR/NAND reduction of one slice
module slice_reduce
  import vec_slice_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] slice,
  input  logic [1:0]         mode,
  output logic               red
);
  always_comb red = mode == MODE_OR  ? |slice :
                    mode == MODE_AND ? &slice :
                    mode == MODE_XOR ? ^slice : ~&slice;
endmodule

// File: rtl/vec_slice_reduce.sv
// vec_slice_reduce: one-slice-per-clock reduction of a captured vector; VEC_SLICE_REDUCE_CHAN_MASK_EN adds chan_mask skipping
module vec_slice_reduce
  import vec_slice_pkg::*;
#(
  parameter int SLICE_W = 4,
  parameter int NCH = 8,
  localparam int IN_W = SLICE_W * NCH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NCH-1:0]  out_data
`ifdef VEC_SLICE_REDUCE_CHAN_MASK_EN
  ,
  input  logic [NCH-1:0]  chan_mask
`endif
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  state_t state, state_n;
  logic [CW-1:0] ch, first_ch, next_ch;
  logic [IN_W-1:0] vec;
  logic [1:0] md;
  logic red, acc, none, last;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign acc = in_valid && in_ready;
`ifdef VEC_SLICE_REDUCE_CHAN_MASK_EN
  logic [NCH-1:0] msk;
  always_comb begin
    first_ch = '0;
    none = 1'b1;
    next_ch = ch;
    last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!chan_mask[i]) begin
        first_ch = CW'(i);
        none = 1'b0;
      end
      if (!msk[i] && i > int'(ch)) begin
        next_ch = CW'(i);
        last = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) msk <= '0;
    else if (acc) msk <= chan_mask;
  end
`else
  assign first_ch = '0;
  assign none = 1'b0;
  assign next_ch = ch + 1'b1;
  assign last = ch == CW'(NCH - 1);
`endif
  slice_reduce #(.SLICE_W(SLICE_W)) u_red (
    .slice(vec[SLICE_W*int'(ch) +: SLICE_W]),
    .mode (md),
    .red  (red)
  );
  always_comb begin
    state_n = state == IDLE ? (in_valid ? (none ? DONE : BUSY) : IDLE) :
              state == BUSY ? (last ? DONE : BUSY) :
              state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      vec <= '0;
      md <= MODE_OR;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        vec <= in_data;
        md <= mode;
        out_data <= '0;
        ch <= first_ch;
      end else if (state == BUSY) begin
        out_data[ch] <= red;
        ch <= last ? '0 : next_ch;
      end
    end
  end
endmodule
